// File: rtl/pool_window_gather_if.sv
// Handshake bundle between the conv pixel stream, the window gatherer and the max-pool stage.
// master drives pixels and window back-pressure; slave is the gatherer itself.
interface pool_window_gather_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_sof;
    logic                     win_valid;
    logic                     win_ready;
    logic [4*DATA_W-1:0]      win_data;
    logic                     win_last;

    modport master (
        output in_valid, in_data, in_sof, win_ready,
        input  in_ready, win_valid, win_data, win_last
    );

    modport slave (
        input  in_valid, in_data, in_sof, win_ready,
        output in_ready, win_valid, win_data, win_last
    );
endinterface

// File: rtl/pool_window_gather.sv
// Collects 2x2 non-overlapping windows from a raster pixel stream and packs them
// as {BR, BL, TR, TL} for the max-pool stage, with lossless valid/ready flow control.
module pool_window_gather #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    pool_window_gather_if.slave bus
);
    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_geometry
        $error("pool_window_gather: IMG_W and IMG_H must be even and >= 2");
    end

    function automatic logic [4*DATA_W-1:0] pack_window(
        input logic signed [DATA_W-1:0] tl,
        input logic signed [DATA_W-1:0] tr,
        input logic signed [DATA_W-1:0] bl,
        input logic signed [DATA_W-1:0] br
    );
        return {br, bl, tr, tl};
    endfunction

    logic                     w_accept;
    logic                     w_consume;
    logic                     w_load;
    logic                     w_last;
    logic [COL_W-1:0]         w_col;
    logic [ROW_W-1:0]         w_row;
    logic [COL_W-1:0]         w_col_nxt;
    logic [ROW_W-1:0]         w_row_nxt;
    logic signed [DATA_W-1:0] w_tl;
    logic signed [DATA_W-1:0] w_tr;

    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;
    logic signed [DATA_W-1:0] r_hold_p0;
    logic signed [DATA_W-1:0] r_linebuf [IMG_W];
    logic [4*DATA_W-1:0]      r_win_data_p1;
    logic                     r_win_vld_p1;
    logic                     r_win_last_p1;

    // Single-entry output register: refill is allowed in the same cycle it drains.
    assign bus.in_ready  = !r_win_vld_p1 | bus.win_ready;
    assign bus.win_valid = r_win_vld_p1;
    assign bus.win_data  = r_win_data_p1;
    assign bus.win_last  = r_win_last_p1;

    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_consume = r_win_vld_p1 & bus.win_ready;

    // in_sof pins the accepted beat to (0,0), abandoning any half-built window.
    assign w_col = bus.in_sof ? '0 : r_col;
    assign w_row = bus.in_sof ? '0 : r_row;

    assign w_load = w_accept & w_row[0] & w_col[0];
    assign w_last = (w_row == ROW_LAST) && (w_col == COL_LAST);
    assign w_tl   = r_linebuf[w_col - COL_W'(1)];
    assign w_tr   = r_linebuf[w_col];

    always_comb begin
        w_col_nxt = w_col + COL_W'(1);
        w_row_nxt = w_row;
        if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + ROW_W'(1);
        end
    end

    // p0: raster position and bottom-left hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_hold_p0 <= '0;
        end else if (w_accept) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            if (w_row[0] && !w_col[0]) begin
                r_hold_p0 <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !w_row[0]) begin
            r_linebuf[w_col] <= bus.in_data;
        end
    end

    // p1: packed window towards the pool stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_vld_p1  <= 1'b0;
            r_win_data_p1 <= '0;
            r_win_last_p1 <= 1'b0;
        end else if (w_load) begin
            r_win_vld_p1  <= 1'b1;
            r_win_data_p1 <= pack_window(w_tl, w_tr, r_hold_p0, bus.in_data);
            r_win_last_p1 <= w_last;
        end else if (w_consume) begin
            r_win_vld_p1 <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pool_window_gather.sv
// Scoreboard bench: a 4x4 instance for fixed-value windows and a 24x24 instance for full frames.
module tb_pool_window_gather;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pool_window_gather_if #(.DATA_W(8)) b4 ();
    pool_window_gather_if #(.DATA_W(8)) b24 ();

    pool_window_gather #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );
    pool_window_gather #(.DATA_W(8), .IMG_W(24), .IMG_H(24)) dut24 (
        .clk(clk), .rst_n(rst_n), .bus(b24)
    );

    int n_pass = 0;
    int n_checks = 0;
    int cnt4 = 0;
    int cnt24 = 0;
    bit bp_rand = 0;
    logic [32:0] q4[$];
    logic [32:0] q24[$];

    logic [7:0]  m_lb[24];
    logic [7:0]  m_hold;
    int          m_col;
    int          m_row;
    logic [32:0] m_last_exp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && b4.win_valid && b4.win_ready) begin
            cnt4++;
            if (q4.size() == 0) check_eq("sb4_depth", 64'(q4.size()), 1);
            else check_eq("win4", {b4.win_last, b4.win_data}, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n && b24.win_valid && b24.win_ready) begin
            cnt24++;
            if (q24.size() == 0) check_eq("sb24_depth", 64'(q24.size()), 1);
            else check_eq("win24", {b24.win_last, b24.win_data}, q24.pop_front());
        end
    end

    task automatic model24(input logic [7:0] d, input bit sof);
        if (sof) begin
            m_col = 0;
            m_row = 0;
        end
        if (m_row % 2 == 0) m_lb[m_col] = d;
        else if (m_col % 2 == 0) m_hold = d;
        else begin
            m_last_exp = {(m_row == 23 && m_col == 23), d, m_hold, m_lb[m_col], m_lb[m_col-1]};
            q24.push_back(m_last_exp);
        end
        m_col++;
        if (m_col == 24) begin
            m_col = 0;
            m_row = (m_row == 23) ? 0 : m_row + 1;
        end
    endtask

    task automatic drv4(input logic [7:0] d, input bit sof);
        int budget = 0;
        bit acc = 0;
        b4.in_valid = 1'b1;
        b4.in_data  = d;
        b4.in_sof   = sof;
        while (!acc) begin
            #1 acc = b4.in_ready;
            @(negedge clk);
            if (!acc && ++budget > 100) begin
                check_eq("drv4_accept", 64'(acc), 1);
                break;
            end
        end
        b4.in_valid = 1'b0;
        b4.in_sof   = 1'b0;
    endtask

    task automatic drv24(input logic [7:0] d, input bit sof);
        int budget = 0;
        bit acc = 0;
        b24.in_valid = 1'b1;
        b24.in_data  = d;
        b24.in_sof   = sof;
        while (!acc) begin
            if (bp_rand) b24.win_ready = ($urandom_range(0, 3) != 0);
            #1 acc = b24.in_ready;
            @(negedge clk);
            if (!acc && ++budget > 200) begin
                check_eq("drv24_accept", 64'(acc), 1);
                break;
            end
        end
        if (acc) model24(d, sof);
        b24.in_valid = 1'b0;
        b24.in_sof   = 1'b0;
    endtask

    task automatic frame24(input int stall_at, input bit rnd, input int cut, input bit first_sof);
        int c0;
        int npix;
        logic [7:0] d;
        c0 = cnt24;
        npix = (cut < 0) ? 576 : cut;
        bp_rand = rnd;
        for (int i = 0; i < npix; i++) begin
            d = 8'($urandom);
            drv24(d, first_sof && i == 0);
            if (rnd && $urandom_range(0, 7) == 0) @(negedge clk);
            if (i == stall_at) begin
                b24.win_ready = 1'b0;
                b24.in_valid  = 1'b1;
                b24.in_data   = 8'($urandom);
                for (int k = 0; k < 5; k++) begin
                    #1;
                    check_eq("stall_in_ready", 64'(b24.in_ready), 0);
                    check_eq("stall_valid", 64'(b24.win_valid), 1);
                    check_eq("stall_data", b24.win_data, m_last_exp[31:0]);
                    @(negedge clk);
                end
                b24.in_valid  = 1'b0;
                b24.win_ready = 1'b1;
            end
        end
        bp_rand = 0;
        b24.win_ready = 1'b1;
        repeat (4) @(negedge clk);
        if (cut < 0) check_eq("count24", 64'(cnt24 - c0), 144);
        check_eq("sb24_left", 64'(q24.size()), 0);
    endtask

    logic [7:0] sgn_pix[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        b4.in_valid = 0; b4.in_data = 0; b4.in_sof = 0; b4.win_ready = 0;
        b24.in_valid = 0; b24.in_data = 0; b24.in_sof = 0; b24.win_ready = 0;
        m_col = 0; m_row = 0; m_hold = 0; m_last_exp = 0;
        #12;
        check_eq("rst4_valid", 64'(b4.win_valid), 0);
        check_eq("rst4_data", b4.win_data, 0);
        check_eq("rst4_last", 64'(b4.win_last), 0);
        check_eq("rst4_in_ready", 64'(b4.in_ready), 1);
        check_eq("rst24_valid", 64'(b24.win_valid), 0);
        check_eq("rst24_in_ready", 64'(b24.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b4.win_ready  = 1'b1;
        b24.win_ready = 1'b1;

        // 4x4 raster 0..15
        q4.push_back({1'b0, 32'h0504_0100});
        q4.push_back({1'b0, 32'h0706_0302});
        q4.push_back({1'b0, 32'h0D0C_0908});
        q4.push_back({1'b1, 32'h0F0E_0B0A});
        for (int i = 0; i < 16; i++) begin
            drv4(8'(i), i == 0);
            check_eq("lat4_valid", 64'(b4.win_valid), 64'(((i >> 2) & 1) & (i & 1)));
        end
        repeat (3) @(negedge clk);
        check_eq("count4", 64'(cnt4), 4);
        check_eq("sb4_left", 64'(q4.size()), 0);

        // signed extremes pass through untouched
        foreach (sgn_pix[i]) sgn_pix[i] = 8'h00;
        sgn_pix[0] = 8'h80; sgn_pix[1] = 8'h7F; sgn_pix[4] = 8'hFF; sgn_pix[5] = 8'h01;
        q4.push_back({1'b0, 32'h01FF_7F80});
        q4.push_back({1'b0, 32'h0000_0000});
        q4.push_back({1'b0, 32'h0000_0000});
        q4.push_back({1'b1, 32'h0000_0000});
        for (int i = 0; i < 16; i++) drv4(sgn_pix[i], i == 0);
        repeat (3) @(negedge clk);
        check_eq("sb4_left_sgn", 64'(q4.size()), 0);

        // full frame with a 5-cycle stall on the first window, then random back-pressure
        frame24(25, 0, -1, 1);
        frame24(-1, 1, -1, 1);

        // restart mid row 1, then a clean frame
        frame24(-1, 0, 29, 1);
        frame24(-1, 0, -1, 1);

        // async reset while a window is pending
        for (int i = 0; i < 26; i++) drv24(8'($urandom), i == 0);
        b24.win_ready = 1'b0;
        #1 check_eq("pre_rst_valid", 64'(b24.win_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(b24.win_valid), 0);
        check_eq("async_rst_last", 64'(b24.win_last), 0);
        check_eq("async_rst_in_ready", 64'(b24.in_ready), 1);
        q24.delete();
        m_col = 0; m_row = 0; m_hold = 0;
        @(negedge clk);
        rst_n = 1'b1;
        b24.win_ready = 1'b1;
        @(negedge clk);
        frame24(-1, 0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
